// File: rtl/rns_pkg.sv
// Shared constants and residue types for the {32, 31, 63} residue number system.
package rns_pkg;

  localparam int RNS_N     = 5;
  localparam int M1        = 32;
  localparam int M2        = 31;
  localparam int M3        = 63;
  localparam int DYN_RANGE = 62496;

  typedef logic [RNS_N-1:0] res5_t;
  typedef logic [RNS_N:0]   res6_t;

endpackage

// File: rtl/mod_2k1_reduce.sv
// Combinational reduction of a fold sum modulo 2^K-1: two end-around folds,
// then the all-ones pattern (congruent to zero) is mapped to 0.
module mod_2k1_reduce #(
  parameter int K = 5,
  parameter int W = 7
) (
  input  logic [W-1:0] v,
  output logic [K-1:0] r
);

  localparam int W1 = K + 1;

  logic [K:0]   hi;
  logic [K:0]   fold1;
  logic [K-1:0] fold2;

  // After the first fold the carry is at most a few units, so the second
  // fold always fits back in K bits.
  assign hi    = W1'(v[W-1:K]);
  assign fold1 = {1'b0, v[K-1:0]} + hi;
  assign fold2 = fold1[K-1:0] + K'(fold1[K]);
  assign r     = (fold2 == {K{1'b1}}) ? '0 : fold2;

endmodule

// File: rtl/rns_forward_conv.sv
// Two-stage valid/ready binary-to-residue converter for moduli {32, 31, 63}.
// Optional range check on the operand is enabled by RNS_FWD_RANGE_CHK_EN.
module rns_forward_conv
  import rns_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  r1,
  output logic [4:0]  r2,
  output logic [5:0]  r3
`ifdef RNS_FWD_RANGE_CHK_EN
  ,
  output logic        out_err
`endif
);

  logic       s1_valid;
  res5_t      s1_r1;
  logic [6:0] s1_s31;
  logic [7:0] s1_s63;
  logic       s1_load;
  logic       s2_load;
  logic [6:0] s31;
  logic [7:0] s63;
  res5_t      red31;
  res6_t      red63;

  assign s2_load  = s1_valid && (!out_valid || out_ready);
  assign in_ready = rst_n && (!s1_valid || !out_valid || out_ready);
  assign s1_load  = in_valid && in_ready;

  // Weights 2^5 = 1 (mod 31) and 2^6 = 1 (mod 63) let each chunk simply add.
  assign s31 = 7'(in_x[4:0]) + 7'(in_x[9:5]) + 7'(in_x[14:10]) + 7'(in_x[15]);
  assign s63 = 8'(in_x[5:0]) + 8'(in_x[11:6]) + 8'(in_x[15:12]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_r1    <= '0;
      s1_s31   <= '0;
      s1_s63   <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_r1    <= in_x[4:0];
        s1_s31   <= s31;
        s1_s63   <= s63;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  mod_2k1_reduce #(.K(5), .W(7)) u_red31 (
    .v (s1_s31),
    .r (red31)
  );

  mod_2k1_reduce #(.K(6), .W(8)) u_red63 (
    .v (s1_s63),
    .r (red63)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      r1        <= '0;
      r2        <= '0;
      r3        <= '0;
    end else begin
      if (s2_load) begin
        out_valid <= 1'b1;
        r1        <= s1_r1;
        r2        <= red31;
        r3        <= red63;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef RNS_FWD_RANGE_CHK_EN
  localparam logic [15:0] X_MAX = 16'(DYN_RANGE - 1);

  logic s1_err;

  // The flag travels with its operand so it always lines up with the residues.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_err  <= 1'b0;
      out_err <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_err <= (in_x > X_MAX);
      end
      if (s2_load) begin
        out_err <= s1_err;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rns_forward_conv.sv
// Directed and table-driven bench for rns_forward_conv with an in-order
// scoreboard of expected residues.
module tb_rns_forward_conv;

  typedef struct {
    logic [15:0] x;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [5:0]  r3;
    logic        err;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  r1;
  logic [4:0]  r2;
  logic [5:0]  r3;
`ifdef RNS_FWD_RANGE_CHK_EN
  logic        out_err;
`endif

  int   compared = 0;
  int   mismatched = 0;
  int   acc_count = 0;
  int   out_count = 0;
  vec_t exp_q[$];

  rns_forward_conv dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r1        (r1),
    .r2        (r2),
`ifdef RNS_FWD_RANGE_CHK_EN
    .r3        (r3),
    .out_err   (out_err)
`else
    .r3        (r3)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input int x);
    vec_t v;
    v.x   = 16'(x);
    v.r1  = 5'(x % 32);
    v.r2  = 5'(x % 31);
    v.r3  = 6'(x % 63);
    v.err = (x > 62495);
    return v;
  endfunction

  task automatic checkOutput(input string name, input int act, input int expv);
    compared++;
    if (act != expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Drive one cycle at the falling edge and score the handshakes that the
  // next rising edge will complete.
  task automatic applyStimulus(input logic v, input vec_t vec, input logic rdy);
    vec_t e;
    @(negedge clk);
    in_valid  = v;
    in_x      = vec.x;
    out_ready = rdy;
    #1;
    if (out_valid) begin
      checkOutput("r2_not_31", int'(r2 != 5'd31), 1);
      checkOutput("r3_not_63", int'(r3 != 6'd63), 1);
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_output", 1, 0);
      end else begin
        e = exp_q.pop_front();
        checkOutput("r1", int'(r1), int'(e.r1));
        checkOutput("r2", int'(r2), int'(e.r2));
        checkOutput("r3", int'(r3), int'(e.r3));
`ifdef RNS_FWD_RANGE_CHK_EN
        checkOutput("out_err", int'(out_err), int'(e.err));
`endif
      end
      out_count++;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(vec);
      acc_count++;
    end
  endtask

  vec_t tbl[6];
  vec_t idle;

  initial begin
    int gaps;
    int start_out;
    int start_acc;
    int x;
    int iter;
    int seen;

    tbl[0] = '{16'd0,     5'd0,  5'd0,  6'd0,  1'b0};
    tbl[1] = '{16'd1000,  5'd8,  5'd8,  6'd55, 1'b0};
    tbl[2] = '{16'd31,    5'd31, 5'd0,  6'd31, 1'b0};
    tbl[3] = '{16'd63,    5'd31, 5'd1,  6'd0,  1'b0};
    tbl[4] = '{16'd62495, 5'd31, 5'd30, 6'd62, 1'b0};
    tbl[5] = '{16'd65535, 5'd31, 5'd1,  6'd15, 1'b1};
    idle   = '{16'd0, 5'd0, 5'd0, 6'd0, 1'b0};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_x      = 16'd0;
    out_ready = 1'b0;
    #12;
    checkOutput("reset_in_ready", int'(in_ready), 0);
    checkOutput("reset_out_valid", int'(out_valid), 0);
    checkOutput("reset_r1", int'(r1), 0);
    checkOutput("reset_r2", int'(r2), 0);
    checkOutput("reset_r3", int'(r3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("post_reset_in_ready", int'(in_ready), 1);

    // Directed table: one operand at a time, checking the 2-cycle latency.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, tbl[i], 1'b1);
      checkOutput("tbl_accept", int'(in_ready), 1);
      applyStimulus(1'b0, idle, 1'b1);
      checkOutput("tbl_lat_not_early", int'(out_valid), 0);
      applyStimulus(1'b0, idle, 1'b1);
      checkOutput("tbl_lat_valid", int'(out_valid), 1);
      applyStimulus(1'b0, idle, 1'b1);
      checkOutput("tbl_drained", int'(out_valid), 0);
    end
    checkOutput("tbl_queue_empty", exp_q.size(), 0);

    // Back-to-back stream at full throughput.
    gaps = 0;
    start_out = out_count;
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b1, mk(int'($urandom_range(0, 65535))), 1'b1);
      if (!in_ready) gaps++;
      if (i >= 2 && !out_valid) gaps++;
    end
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, idle, 1'b1);
    checkOutput("stream_gaps", gaps, 0);
    checkOutput("stream_count", out_count - start_out, 1000);

    // Back-pressure: five stalled cycles with a waiting operand.
    start_acc = acc_count;
    x = 12345;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, mk(x), 1'b0);
      if (acc_count != start_acc + i && acc_count - start_acc <= 2) x = x + 777;
      if (out_valid && exp_q.size() > 0) begin
        checkOutput("stall_hold_r1", int'(r1), int'(exp_q[0].r1));
        checkOutput("stall_hold_r2", int'(r2), int'(exp_q[0].r2));
        checkOutput("stall_hold_r3", int'(r3), int'(exp_q[0].r3));
      end
    end
    checkOutput("stall_accepts", acc_count - start_acc, 2);
    checkOutput("stall_in_ready", int'(in_ready), 0);
    checkOutput("stall_out_valid", int'(out_valid), 1);
    start_out = out_count;
    iter = 0;
    while (exp_q.size() > 0 && iter < 10) begin
      applyStimulus(1'b0, idle, 1'b1);
      iter++;
    end
    applyStimulus(1'b0, idle, 1'b1);
    checkOutput("release_count", out_count - start_out, 2);
    checkOutput("release_queue_empty", exp_q.size(), 0);

    // Reset with two operands in flight.
    applyStimulus(1'b1, mk(4242), 1'b0);
    applyStimulus(1'b1, mk(999), 1'b0);
    checkOutput("pre_reset_full", exp_q.size(), 2);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checkOutput("midrst_out_valid", int'(out_valid), 0);
    checkOutput("midrst_r1", int'(r1), 0);
    checkOutput("midrst_r2", int'(r2), 0);
    checkOutput("midrst_r3", int'(r3), 0);
    checkOutput("midrst_in_ready", int'(in_ready), 0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, idle, 1'b1);
      if (i == 0) checkOutput("midrst_ready_after", int'(in_ready), 1);
      if (out_valid) seen++;
    end
    checkOutput("midrst_no_stale", seen, 0);

    // Strided sweep of the whole input space with random back-pressure.
    x = 0;
    iter = 0;
    start_out = out_count;
    while (x <= 65535 && iter < 40000) begin
      start_acc = acc_count;
      applyStimulus(1'b1, mk(x), 1'($urandom_range(0, 4) != 0));
      if (acc_count != start_acc) x = x + 5;
      iter++;
    end
    checkOutput("sweep_done", int'(x > 65535), 1);
    iter = 0;
    while (exp_q.size() > 0 && iter < 20) begin
      applyStimulus(1'b0, idle, 1'b1);
      iter++;
    end
    checkOutput("sweep_queue_empty", exp_q.size(), 0);
    checkOutput("sweep_count", out_count - start_out, 13108);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
